// File: rtl/uart_pkg.sv
// Shared types for the UART core: parity modes, FSM state encodings,
// the RX FIFO entry layout and the parity helper used by both directions.
package uart_pkg;

  localparam int PARITY_NONE   = 0;
  localparam int PARITY_ODD    = 1;
  localparam int PARITY_EVEN   = 2;

  // FIFO entries always carry the widest payload; narrower words are zero-extended.
  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     parity_err;
    logic                     frame_err;
  } rx_entry_t;

  // Parity bit to transmit (or expect) for a word; zero-extension does not change it.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    logic p;
    case (mode)
      PARITY_ODD:  p = ~^data;
      PARITY_EVEN: p = ^data;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_transceiver_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
// A push into a full FIFO is only accepted when a pop frees a slot in the
// same cycle; otherwise it is dropped and o_drop pulses.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_drop,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!w_full || i_pop);
  assign o_drop  = i_push && w_full && !i_pop;
  assign o_count = r_count;

  // Head word is forced to zero while empty so the outputs read clean after reset.
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: shared sample-tick generator, TX and RX state machines,
// and an RX FIFO that keeps per-word parity/frame error flags.
//
// TX states
//   state     | meaning
//   TX_IDLE   | line high, tx_ready=1, waiting for tx_valid
//   TX_START  | word latched; drives start bit from the first tick after accept
//   TX_DATA   | shifting payload out LSB first
//   TX_PARITY | parity bit on the line (only when parity is enabled)
//   TX_STOP   | one or two stop bits; tx_ready returns at the end
//
// RX states
//   state     | meaning
//   RX_IDLE   | waiting for a low sample on a tick
//   RX_START  | counting to mid start bit, false starts go back to idle
//   RX_DATA   | sampling payload bits at mid-bit
//   RX_PARITY | sampling and checking the parity bit
//   RX_STOP   | sampling the first stop bit; pushes the word at mid-stop
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int SAMPLE_RATIO  = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic                          txd,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overflow,
  input  logic                          clr_overflow
);

  localparam int SAMPLE_CLK_RATIO = CLK_FREQUENCY / BAUD_RATE / SAMPLE_RATIO;
  localparam int TICK_W = (SAMPLE_CLK_RATIO > 1) ? $clog2(SAMPLE_CLK_RATIO) : 1;
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(SAMPLE_CLK_RATIO - 1);

  localparam int SR_W = $clog2(SAMPLE_RATIO);
  localparam logic [SR_W-1:0] SR_LOAD = SR_W'(SAMPLE_RATIO - 1);
  localparam logic [SR_W-1:0] SR_HALF = SR_W'(SAMPLE_RATIO / 2 - 1);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  localparam logic STOP_EXTRA = (STOP_BITS == 2);

  // ---------------------------------------------------------------- tick
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  assign w_tick = (r_tick_cnt == '0);

  // Free-running down-counter; terminal count is the sample tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= TICK_LOAD;
    end else if (w_tick) begin
      r_tick_cnt <= TICK_LOAD;
    end else begin
      r_tick_cnt <= r_tick_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX
  tx_state_e            r_tx_state;
  logic                 r_txd;
  logic                 r_tx_ready;
  logic                 r_tx_armed;
  logic [SR_W-1:0]      r_tx_cnt;
  logic [IDX_W-1:0]     r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_stop_left;

  assign txd      = r_txd;
  assign tx_ready = r_tx_ready;
  assign tx_busy  = !r_tx_ready;

  // TX frame sequencer; txd only moves on ticks, one bit per SAMPLE_RATIO ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state     <= TX_IDLE;
      r_txd          <= 1'b1;
      r_tx_ready     <= 1'b1;
      r_tx_armed     <= 1'b0;
      r_tx_cnt       <= '0;
      r_tx_idx       <= '0;
      r_tx_shift     <= '0;
      r_tx_par       <= 1'b0;
      r_tx_stop_left <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_valid && r_tx_ready) begin
            r_tx_shift <= tx_data;
            r_tx_par   <= parity_bit(MAX_DATA_BITS'(tx_data), PARITY);
            r_tx_ready <= 1'b0;
            r_tx_armed <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            // The first tick after accept only starts the start bit.
            if (!r_tx_armed) begin
              r_txd      <= 1'b0;
              r_tx_armed <= 1'b1;
              r_tx_cnt   <= SR_LOAD;
            end else if (r_tx_cnt != '0) begin
              r_tx_cnt <= r_tx_cnt - 1'b1;
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_idx   <= '0;
              r_tx_cnt   <= SR_LOAD;
              r_tx_state <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_tx_cnt != '0) begin
              r_tx_cnt <= r_tx_cnt - 1'b1;
            end else begin
              r_tx_cnt <= SR_LOAD;
              if (r_tx_idx == IDX_LAST) begin
                if (PARITY != PARITY_NONE) begin
                  r_txd      <= r_tx_par;
                  r_tx_state <= TX_PARITY;
                end else begin
                  r_txd          <= 1'b1;
                  r_tx_stop_left <= STOP_EXTRA;
                  r_tx_state     <= TX_STOP;
                end
              end else begin
                r_tx_idx   <= r_tx_idx + 1'b1;
                r_tx_shift <= r_tx_shift >> 1;
                r_txd      <= r_tx_shift[1];
              end
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            if (r_tx_cnt != '0) begin
              r_tx_cnt <= r_tx_cnt - 1'b1;
            end else begin
              r_txd          <= 1'b1;
              r_tx_cnt       <= SR_LOAD;
              r_tx_stop_left <= STOP_EXTRA;
              r_tx_state     <= TX_STOP;
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_tx_cnt != '0) begin
              r_tx_cnt <= r_tx_cnt - 1'b1;
            end else if (r_tx_stop_left) begin
              r_tx_stop_left <= 1'b0;
              r_tx_cnt       <= SR_LOAD;
            end else begin
              r_tx_ready <= 1'b1;
              r_tx_armed <= 1'b0;
              r_tx_state <= TX_IDLE;
            end
          end
        end
        default: begin
          r_txd      <= 1'b1;
          r_tx_ready <= 1'b1;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic                 r_rxd_meta;
  logic                 r_rxd_sync;
  rx_state_e            r_rx_state;
  logic [SR_W-1:0]      r_rx_cnt;
  logic [IDX_W-1:0]     r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_perr;

  logic                 w_rx_push;
  rx_entry_t            w_rx_entry;

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // RX frame sequencer; every sample decision happens on a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_perr  <= 1'b0;
    end else if (w_tick) begin
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rxd_sync) begin
            r_rx_cnt   <= SR_HALF;
            r_rx_perr  <= 1'b0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else if (r_rxd_sync) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt   <= SR_LOAD;
            r_rx_idx   <= '0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            r_rx_shift <= {r_rxd_sync, r_rx_shift[DATA_BITS-1:1]};
            r_rx_cnt   <= SR_LOAD;
            if (r_rx_idx == IDX_LAST) begin
              if (PARITY != PARITY_NONE) begin
                r_rx_state <= RX_PARITY;
              end else begin
                r_rx_state <= RX_STOP;
              end
            end else begin
              r_rx_idx <= r_rx_idx + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            r_rx_perr  <= (r_rxd_sync != parity_bit(MAX_DATA_BITS'(r_rx_shift), PARITY));
            r_rx_cnt   <= SR_LOAD;
            r_rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          // Word is pushed by w_rx_push on the same tick; go hunt for the next start.
          if (r_rx_cnt != '0) begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end else begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign w_rx_push = (r_rx_state == RX_STOP) && w_tick && (r_rx_cnt == '0);

  // Entry assembled from the shift register and the live mid-stop sample.
  always_comb begin
    w_rx_entry                      = '0;
    w_rx_entry.data[DATA_BITS-1:0]  = r_rx_shift;
    w_rx_entry.parity_err           = r_rx_perr;
    w_rx_entry.frame_err            = ~r_rxd_sync;
  end

  // ---------------------------------------------------------------- FIFO
  rx_entry_t w_head;
  logic      w_fifo_empty;
  logic      w_fifo_drop;
  logic      r_overflow;

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_data  (w_rx_entry),
    .i_pop   (rx_ready),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_drop  (w_fifo_drop),
    .o_count (rx_count)
  );

  assign rx_valid      = !w_fifo_empty;
  assign rx_data       = w_head.data[DATA_BITS-1:0];
  assign rx_parity_err = w_head.parity_err;
  assign rx_frame_err  = w_head.frame_err;
  assign rx_overflow   = r_overflow;

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_fifo_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver. Instance 0 is 8N1 with a 4-deep FIFO,
// instance 1 is 8E1 with a 16-deep FIFO. Expected RX words and TX line bits
// are queued when stimulus is driven and popped when the DUT produces them.
module tb_uart_transceiver;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  localparam int BIT_CLK = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass   = 0;
  int n_checks = 0;

  logic       rst_v      [2];
  logic       rxd_v      [2];
  logic       txd_v      [2];
  logic [7:0] tx_data_v  [2];
  logic       tx_valid_v [2];
  logic       tx_ready_v [2];
  logic       tx_busy_v  [2];
  logic [7:0] rx_data_v  [2];
  logic       rx_pe_v    [2];
  logic       rx_fe_v    [2];
  logic       rx_valid_v [2];
  logic       rx_ready_v [2];
  logic       rx_ovf_v   [2];
  logic       clr_ovf_v  [2];
  logic [2:0] cnt0;
  logic [4:0] cnt1;

  exp_t sb_rx[$];
  logic sb_tx[$];
  bit   exp_ovf [2];

  uart_transceiver #(
    .CLK_FREQUENCY(1_600_000), .BAUD_RATE(10_000), .SAMPLE_RATIO(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_8n1 (
    .clk(clk), .reset(rst_v[0]), .rxd(rxd_v[0]), .txd(txd_v[0]),
    .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]), .tx_ready(tx_ready_v[0]),
    .tx_busy(tx_busy_v[0]), .rx_data(rx_data_v[0]), .rx_parity_err(rx_pe_v[0]),
    .rx_frame_err(rx_fe_v[0]), .rx_valid(rx_valid_v[0]), .rx_ready(rx_ready_v[0]),
    .rx_count(cnt0), .rx_overflow(rx_ovf_v[0]), .clr_overflow(clr_ovf_v[0])
  );

  uart_transceiver #(
    .CLK_FREQUENCY(1_600_000), .BAUD_RATE(10_000), .SAMPLE_RATIO(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_8e1 (
    .clk(clk), .reset(rst_v[1]), .rxd(rxd_v[1]), .txd(txd_v[1]),
    .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready_v[1]),
    .tx_busy(tx_busy_v[1]), .rx_data(rx_data_v[1]), .rx_parity_err(rx_pe_v[1]),
    .rx_frame_err(rx_fe_v[1]), .rx_valid(rx_valid_v[1]), .rx_ready(rx_ready_v[1]),
    .rx_count(cnt1), .rx_overflow(rx_ovf_v[1]), .clr_overflow(clr_ovf_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int rx_cnt(input int s);
    return (s == 0) ? int'(cnt0) : int'(cnt1);
  endfunction

  task automatic bit_time(input int s, input logic b);
    rxd_v[s] = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Drives one frame on rxd of instance s and records the word it should yield.
  task automatic drive_frame(input int s, input logic [7:0] d, input bit par_en,
                             input bit par_flip, input bit stop_b, input int depth);
    exp_t e;
    e.data = d;
    e.pe   = par_en && par_flip;
    e.fe   = !stop_b;
    if (sb_rx.size() < depth) sb_rx.push_back(e);
    else exp_ovf[s] = 1'b1;
    bit_time(s, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(s, d[i]);
    if (par_en) bit_time(s, (^d) ^ par_flip);
    bit_time(s, stop_b);
    rxd_v[s] = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic rx_pop_check(input int s, input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (rx_valid_v[s] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_valid"}, seen, 1'b1);
    n_checks++;
    assert (sb_rx.size() != 0) n_pass++;
    else $error("FAIL %s_sb: observed empty scoreboard expected a queued word", tag);
    if (sb_rx.size() != 0) begin
      e = sb_rx.pop_front();
      check({tag, "_data"}, rx_data_v[s], e.data);
      check({tag, "_perr"}, rx_pe_v[s], e.pe);
      check({tag, "_ferr"}, rx_fe_v[s], e.fe);
    end
    rx_ready_v[s] = 1'b1;
    @(negedge clk);
    rx_ready_v[s] = 1'b0;
  endtask

  // Offers d on instance 0, checks the handshake and start latency; c0 = cycle of start bit.
  task automatic tx_start(input logic [7:0] d, input string tag, output int c0);
    int ca;
    bit seen = 1'b0;
    @(negedge clk);
    tx_data_v[0]  = d;
    tx_valid_v[0] = 1'b1;
    check({tag, "_ready_idle"}, tx_ready_v[0], 1'b1);
    @(negedge clk);
    ca = cyc;
    tx_valid_v[0] = 1'b0;
    tx_data_v[0]  = ~d;
    sb_tx.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb_tx.push_back(d[i]);
    sb_tx.push_back(1'b1);
    check({tag, "_ready_fall"}, tx_ready_v[0], 1'b0);
    check({tag, "_busy_rise"}, tx_busy_v[0], 1'b1);
    c0 = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (txd_v[0] === 1'b0) begin
        seen = 1'b1;
        c0   = cyc;
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_start_seen"}, seen, 1'b1);
    check({tag, "_start_latency_le10"}, ((c0 - ca) >= 1) && ((c0 - ca) <= 10), 1'b1);
  endtask

  task automatic tx_check_frame(input int c0, input string tag);
    logic b;
    bit   seen = 1'b0;
    int   c1   = 0;
    repeat (BIT_CLK / 2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      b = sb_tx.pop_front();
      check($sformatf("%s_bit%0d", tag, k), txd_v[0], b);
      if (k < 9) repeat (BIT_CLK) @(negedge clk);
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_ready_v[0] === 1'b1) begin
        seen = 1'b1;
        c1   = cyc;
      end
    end
    check({tag, "_ready_rise"}, seen, 1'b1);
    check({tag, "_frame_len"}, c1 - c0, 32'd1600);
    check({tag, "_busy_fall"}, tx_busy_v[0], 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int s = 0; s < 2; s++) begin
      rst_v[s]      = 1'b1;
      rxd_v[s]      = 1'b1;
      tx_data_v[s]  = 8'h00;
      tx_valid_v[s] = 1'b0;
      rx_ready_v[s] = 1'b0;
      clr_ovf_v[s]  = 1'b0;
      exp_ovf[s]    = 1'b0;
    end
    repeat (5) @(negedge clk);
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    @(negedge clk);

    // reset values
    check("rst_txd", txd_v[0], 1'b1);
    check("rst_tx_ready", tx_ready_v[0], 1'b1);
    check("rst_tx_busy", tx_busy_v[0], 1'b0);
    check("rst_rx_valid", rx_valid_v[0], 1'b0);
    check("rst_rx_count", rx_cnt(0), 0);
    check("rst_rx_ovf", rx_ovf_v[0], 1'b0);
    check("rst_rx_data", rx_data_v[0], 8'h00);
    check("rst_rx_perr", rx_pe_v[0], 1'b0);
    check("rst_rx_ferr", rx_fe_v[0], 1'b0);
    check("rst_e_txd", txd_v[1], 1'b1);
    check("rst_e_rx_count", rx_cnt(1), 0);

    // TX 0xA5 8N1
    tx_start(8'hA5, "txa5", c0);
    tx_check_frame(c0, "txa5");

    // RX 0x3C even parity, clean
    drive_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1, 16);
    check("rx3c_count", rx_cnt(1), 1);
    rx_pop_check(1, "rx3c");
    check("rx3c_valid_after_pop", rx_valid_v[1], 1'b0);
    check("rx3c_count_after_pop", rx_cnt(1), 0);

    // RX 0x3C with wrong parity bit
    drive_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 16);
    rx_pop_check(1, "rx3c_perr");

    // RX 0x55 with stop bit low
    drive_frame(1, 8'h55, 1'b1, 1'b0, 1'b0, 16);
    repeat (2 * BIT_CLK) @(negedge clk);
    check("rx55_count", rx_cnt(1), 1);
    rx_pop_check(1, "rx55_ferr");
    check("rx55_valid_after_pop", rx_valid_v[1], 1'b0);

    // 40-clk glitch is a false start
    rxd_v[1] = 1'b0;
    repeat (40) @(negedge clk);
    rxd_v[1] = 1'b1;
    repeat (3 * BIT_CLK) @(negedge clk);
    check("glitch_count", rx_cnt(1), 0);
    check("glitch_valid", rx_valid_v[1], 1'b0);

    // overflow on the 4-deep FIFO
    for (int i = 1; i <= 4; i++) drive_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 4);
    check("ovf_count_full", rx_cnt(0), 4);
    check("ovf_flag_before", rx_ovf_v[0], exp_ovf[0]);
    drive_frame(0, 8'h05, 1'b0, 1'b0, 1'b1, 4);
    check("ovf_count_after", rx_cnt(0), 4);
    check("ovf_flag_after", rx_ovf_v[0], exp_ovf[0]);
    for (int i = 1; i <= 4; i++) rx_pop_check(0, $sformatf("ovf_pop%0d", i));
    check("ovf_drained_valid", rx_valid_v[0], 1'b0);
    check("ovf_flag_sticky", rx_ovf_v[0], exp_ovf[0]);
    clr_ovf_v[0] = 1'b1;
    @(negedge clk);
    clr_ovf_v[0] = 1'b0;
    exp_ovf[0]   = 1'b0;
    check("ovf_flag_cleared", rx_ovf_v[0], exp_ovf[0]);

    // reset during data bit 3 of 0xFF, then a clean 0x0F frame
    tx_start(8'hFF, "txff", c0);
    repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
    check("txff_busy_mid", tx_busy_v[0], 1'b1);
    rst_v[0] = 1'b1;
    sb_tx.delete();
    sb_rx.delete();
    @(negedge clk);
    check("txrst_txd", txd_v[0], 1'b1);
    check("txrst_ready", tx_ready_v[0], 1'b1);
    check("txrst_busy", tx_busy_v[0], 1'b0);
    rst_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    check("txrst_txd_idle", txd_v[0], 1'b1);
    tx_start(8'h0F, "tx0f", c0);
    tx_check_frame(c0, "tx0f");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Parametrised full-duplex UART core: configurable data width, parity mode and stop-bit count, with a 16x-oversampled receiver, a valid/ready transmit port and a buffered receive FIFO carrying per-word error flags. It is the successor of the fixed 8N1 echo transceiver. It sits between the board serial pins (`rxd`/`txd`) and user logic. All pacing derives from `clk` through clock-enable ticks; no derived clocks.

## Interface
- `CLK_FREQUENCY`, 100_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, 9600: line rate.
- `SAMPLE_RATIO`, 16: oversampling ticks per bit; even, ≥ 4.
- `DATA_BITS`, 8: payload bits, 5..8.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: RX FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rxd` in 1: serial input, asynchronous, idle high.
- `txd` out 1: serial output, idle high.
- `tx_data` in DATA_BITS: word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmitter idle; transfer occurs on `tx_valid && tx_ready`.
- `tx_busy` out 1: frame in progress; equals `!tx_ready`.
- `rx_data` out DATA_BITS: FIFO head word, first-word fall-through.
- `rx_parity_err` out 1: parity error flag of the head word.
- `rx_frame_err` out 1: stop-bit error flag of the head word.
- `rx_valid` out 1: FIFO not empty.
- `rx_ready` in 1: pops the head on `rx_valid && rx_ready`.
- `rx_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `rx_overflow` out 1: sticky; a frame was dropped because the FIFO was full.
- `clr_overflow` in 1: clears `rx_overflow`.

## Operation
- **Sample tick.** `SAMPLE_CLK_RATIO = CLK_FREQUENCY/BAUD_RATE/SAMPLE_RATIO` (integer division).
  - A free-running counter pulses `tick` for one `clk` every SAMPLE_CLK_RATIO cycles.
  - One bit time is SAMPLE_RATIO ticks.
- **TX FSM:** IDLE → START → DATA (DATA_BITS, LSB first) → PARITY (only if PARITY≠0) → STOP (STOP_BITS bits) → IDLE.
  - On accept, `tx_data` is latched; later changes to `tx_data` are ignored.
  - `txd` changes only on `tick`. The START bit begins at the first tick after accept.
  - Odd parity: `~^data`. Even parity: `^data`.
- **RX path:** `rxd` passes through a 2-FF synchroniser.
  - IDLE: a low sample on a tick enters START.
  - START: at sample SAMPLE_RATIO/2 the line is re-checked. If high, the false start is discarded and the FSM returns to IDLE.
  - DATA and PARITY bits are sampled at mid-bit, i.e. every SAMPLE_RATIO ticks after the start mid-point.
  - STOP: only the first stop bit is checked. Low sets `frame_err`.
  - At the mid-stop sample, {data, parity_err, frame_err} is pushed to the FIFO and the FSM returns to IDLE immediately, ready for the next start edge.
  - Errored words are still pushed.
- **FIFO.**
  - Push when full: the word is dropped and `rx_overflow` is set.
  - Push and pop in the same cycle: both happen; on a full FIFO this does not overflow.
  - A push into an empty FIFO is visible (`rx_valid=1`) the next cycle.
  - `clr_overflow` and a simultaneous overflow in the same cycle: the flag stays set.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:** `txd`=1, `tx_ready`=1, `tx_busy`=0, `rx_valid`=0, `rx_count`=0, `rx_overflow`=0, `rx_data`/error flags=0. The tick counter and both FSMs are set to IDLE.
- **Reset mid-frame:** the frame is aborted and `txd`=1 from the cycle after `reset` is sampled. Any partial RX word is discarded.
- **TX frame length:** (1+DATA_BITS+(PARITY≠0)+STOP_BITS) × SAMPLE_RATIO ticks.
  - `tx_ready` falls the cycle after accept.
  - `tx_ready` rises on the tick that ends the last stop bit.
  - Start-bit latency after accept: at most SAMPLE_CLK_RATIO clk.
- **RX latency:** a word appears on `rx_valid` 1 clk after the mid-stop tick.
- `rx_count` updates 1 clk after the push or pop.

## Structure
- Package `uart_pkg`: parity-mode constants, TX/RX state enums, and a packed RX FIFO entry struct {data, parity_err, frame_err}.
- Tick generator and both FSMs live inline in `uart_transceiver`.
- One sub-module: `sync_fifo` (parametrised width/depth, FWFT, count output).

## Test plan
Bench parameters: CLK_FREQUENCY=1_600_000, BAUD_RATE=10_000, SAMPLE_RATIO=16 (SAMPLE_CLK_RATIO=10, bit = 160 clk), 8N1 unless stated.
- **TX:** send 0xA5 → `txd` reads 0,1,0,1,0,0,1,0,1,1 at 160-clk intervals; `tx_ready` is low for exactly 1600 clk; start-bit latency ≤ 10 clk.
- **RX:** drive 0x3C with PARITY=2 (parity bit 0) → `rx_data`=0x3C, `rx_parity_err`=0, `rx_frame_err`=0, `rx_count`=1; pop → `rx_valid`=0.
- **RX errors:** drive 0x3C with parity bit 1 → `rx_parity_err`=1. Drive 0x55 with stop bit low → `rx_frame_err`=1, data 0x55 still delivered.
- **Glitch:** `rxd` low for 40 clk, then high → no push, `rx_count` stays 0.
- **Overflow:** FIFO_DEPTH=4, 5 frames 0x01..0x05 with no pops → `rx_count`=4, `rx_overflow`=1, pops return 0x01..0x04. `clr_overflow` → flag 0.
- **Reset mid-TX:** assert `reset` during data bit 3 of 0xFF → `txd`=1 next cycle, `tx_ready`=1. A following send of 0x0F frames correctly.
